wishbone_bram_pipelined: RTL and testbench

- Parametrised successor to the single-cycle Wishbone BRAM target.
- Byte-lane block RAM exposed as a Wishbone Classic Pipelined target.
- Adds: selectable read latency (1 or 2), internal or external parity, parity checking with ERR response, a saturating error counter, and response abort on CYC drop.
- Never stalls; one request accepted per clock.

---
 rtl/wishbone_bram_pipelined_pkg.sv | 27 ++
 rtl/wishbone_bram_pipelined_bram_byte_array.sv | 39 +++
 rtl/wishbone_bram_pipelined.sv | 147 ++++++++++++++
 tb/tb_wishbone_bram_pipelined.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wishbone_bram_pipelined_pkg.sv
// Shared constants and parity helpers for the pipelined Wishbone block RAM target.
// Parity is even parity: the stored bit equals the XOR of the byte it guards.
package wishbone_bram_pkg;

  localparam string PARITY_NONE     = "None";
  localparam string PARITY_INTERNAL = "Internal";
  localparam string PARITY_EXTERNAL = "External";

  // Widest supported data bus (64 bits, 8 lanes); narrower buses are zero-extended.
  localparam int MAX_LANES = 8;

  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

  function automatic logic lane_parity_check(input logic [8*MAX_LANES-1:0] data,
                                             input logic [MAX_LANES-1:0]   parity,
                                             input logic [MAX_LANES-1:0]   sel);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (sel[i] && (byte_parity(data[8*i +: 8]) != parity[i])) bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/wishbone_bram_pipelined_bram_byte_array.sv
// Byte-lane RAM: one independent memory per lane so tools infer byte-write block RAM.
// Read-first, registered read port enabled by en; lane writes gated by we[i].
module bram_byte_array #(
  parameter int    AddressWidth = 12,
  parameter int    NumLanes     = 4,
  parameter int    LaneWidth    = 9,
  parameter string DeviceType   = "Xilinx"
) (
  input  logic                          CLK,
  input  logic                          en,
  input  logic [NumLanes-1:0]           we,
  input  logic [AddressWidth-1:0]       addr,
  input  logic [NumLanes*LaneWidth-1:0] din,
  output logic [NumLanes*LaneWidth-1:0] dout
);

  localparam int Depth = 2 ** AddressWidth;

  for (genvar i = 0; i < NumLanes; i++) begin : g_lane
    logic [LaneWidth-1:0] lane_q;

    if (DeviceType == "Xilinx") begin : g_xilinx
      (* ram_style = "block" *) logic [LaneWidth-1:0] mem [Depth];
      always_ff @(posedge CLK) begin
        if (we[i]) mem[addr] <= din[i*LaneWidth +: LaneWidth];
        if (en)    lane_q    <= mem[addr];
      end
    end else begin : g_generic
      logic [LaneWidth-1:0] mem [Depth];
      always_ff @(posedge CLK) begin
        if (we[i]) mem[addr] <= din[i*LaneWidth +: LaneWidth];
        if (en)    lane_q    <= mem[addr];
      end
    end

    assign dout[i*LaneWidth +: LaneWidth] = lane_q;
  end

endmodule

// File: rtl/wishbone_bram_pipelined.sv
// Wishbone Classic Pipelined block RAM target with byte lanes, optional parity,
// selectable read latency, ERR on parity mismatch and a saturating error counter.
module wishbone_bram_pipelined
  import wishbone_bram_pkg::*;
#(
  parameter int    AddressWidth = 12,
  parameter int    DataWidth    = 32,
  parameter int    ReadLatency  = 1,
  parameter string ParityMode   = PARITY_INTERNAL,
  parameter string DeviceType   = "Xilinx"
) (
  input  logic                    CLK,
  input  logic                    RST_n,
  input  logic                    CYC,
  input  logic                    STB,
  input  logic                    WE,
  input  logic [AddressWidth-1:0] ADDR,
  input  logic [DataWidth/8-1:0]  SEL,
  input  logic [DataWidth-1:0]    DAT_ToTarget,
  input  logic [DataWidth/8-1:0]  TGD_ToTarget,
  output logic [DataWidth-1:0]    DAT_ToInitiator,
  output logic [DataWidth/8-1:0]  TGD_ToInitiator,
  output logic                    ACK,
  output logic                    ERR,
  output logic                    STALL,
  input  logic                    ErrClear,
  output logic [15:0]             ErrCount
);

  localparam int NB        = DataWidth / 8;
  localparam bit HasParity = (ParityMode != PARITY_NONE);
  localparam int LaneWidth = HasParity ? 9 : 8;
  localparam int Last      = ReadLatency - 1;

  // Handshake: a request is taken on every edge with CYC&STB (STALL is never raised);
  // its ACK or ERR follows exactly ReadLatency edges later, in order, and is
  // suppressed for any request still in flight when CYC is low.
  logic          accept, rd_en;
  logic [NB-1:0] wr_lane, par_in;
  assign accept  = CYC & STB;
  assign rd_en   = accept & ~WE;
  assign wr_lane = (accept & WE) ? SEL : '0;

  always_comb begin
    par_in = '0;
    for (int i = 0; i < NB; i++) begin
      par_in[i] = (ParityMode == PARITY_EXTERNAL) ? TGD_ToTarget[i]
                                                  : byte_parity(DAT_ToTarget[8*i +: 8]);
    end
  end

  logic [NB*LaneWidth-1:0] ram_din, ram_dout;
  logic [DataWidth-1:0]    rd_data;
  logic [NB-1:0]           rd_par;

  for (genvar i = 0; i < NB; i++) begin : g_pack
    if (HasParity) begin : g_par
      assign ram_din[i*LaneWidth +: LaneWidth] = {par_in[i], DAT_ToTarget[8*i +: 8]};
      assign rd_par[i] = ram_dout[i*LaneWidth + 8];
    end else begin : g_nopar
      assign ram_din[i*LaneWidth +: LaneWidth] = DAT_ToTarget[8*i +: 8];
      assign rd_par[i] = 1'b0;
    end
    assign rd_data[8*i +: 8] = ram_dout[i*LaneWidth +: 8];
  end

  bram_byte_array #(
    .AddressWidth(AddressWidth),
    .NumLanes    (NB),
    .LaneWidth   (LaneWidth),
    .DeviceType  (DeviceType)
  ) u_ram (
    .CLK (CLK),
    .en  (rd_en),
    .we  (wr_lane),
    .addr(ADDR),
    .din (ram_din),
    .dout(ram_dout)
  );

  logic [ReadLatency-1:0] vld_q, we_q;
  logic [NB-1:0]          sel_q [ReadLatency];

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      vld_q <= '0;
      we_q  <= '0;
      for (int k = 0; k < ReadLatency; k++) sel_q[k] <= '0;
    end else begin
      for (int k = ReadLatency - 1; k > 0; k--) begin
        vld_q[k] <= vld_q[k-1];
        we_q[k]  <= we_q[k-1];
        sel_q[k] <= sel_q[k-1];
      end
      vld_q[0] <= accept;
      we_q[0]  <= WE;
      sel_q[0] <= SEL;
      if (!CYC) vld_q <= '0;
    end
  end

  logic [DataWidth-1:0] resp_data;
  logic [NB-1:0]        resp_par;

  if (ReadLatency == 2) begin : g_lat2
    logic [DataWidth-1:0] dat_q;
    logic [NB-1:0]        par_q;
    always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
        dat_q <= '0;
        par_q <= '0;
      end else if (vld_q[0] && !we_q[0]) begin
        dat_q <= rd_data;
        par_q <= rd_par;
      end
    end
    assign resp_data = dat_q;
    assign resp_par  = par_q;
  end else begin : g_lat1
    // The RAM output is not reset, so it is masked to zero until the first read.
    logic shown_q;
    always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n)     shown_q <= 1'b0;
      else if (rd_en) shown_q <= 1'b1;
    end
    assign resp_data = shown_q ? rd_data : '0;
    assign resp_par  = shown_q ? rd_par  : '0;
  end

  logic resp_vld, par_bad;
  assign resp_vld = vld_q[Last] & CYC;
  assign par_bad  = HasParity && !we_q[Last] &&
                    lane_parity_check(64'(resp_data), 8'(resp_par), 8'(sel_q[Last]));

  assign ACK             = resp_vld & ~par_bad;
  assign ERR             = resp_vld & par_bad;
  assign STALL           = 1'b0;
  assign DAT_ToInitiator = resp_data;
  assign TGD_ToInitiator = resp_par;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n)                           ErrCount <= '0;
    else if (ErrClear)                    ErrCount <= '0;
    else if (ERR && ErrCount != 16'hFFFF) ErrCount <= ErrCount + 16'd1;
  end

endmodule

// File: tb/tb_wishbone_bram_pipelined.sv
// Bench for wishbone_bram_pipelined: four instances (latency 1/2 x Internal/External parity)
// share one request stream; per-instance expected queues are checked on the falling edge.
module tb_wishbone_bram_pipelined;

  typedef struct {
    int          due;
    logic        is_rd;
    logic        exp_err;
    logic [31:0] data;
    logic [3:0]  par;
  } exp_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  logic        cyc, stb, we, err_clear;
  logic [11:0] addr;
  logic [3:0]  sel, tgd;
  logic [31:0] dat;

  logic [31:0] dat_o     [4];
  logic [3:0]  tgd_o     [4];
  logic        ack       [4];
  logic        err       [4];
  logic        stall     [4];
  logic [15:0] err_count [4];

  exp_t        exp_q [4][$];
  logic [15:0] exp_cnt [4];

  logic [31:0] m_data [4096];
  logic [3:0]  m_pint [4096];
  logic [3:0]  m_pext [4096];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at edge %0d", tag, got, exp, edge_n);
    end
  endtask

  function automatic logic [3:0] good_par(input logic [31:0] d);
    logic [3:0] p;
    for (int i = 0; i < 4; i++) p[i] = ^d[8*i +: 8];
    return p;
  endfunction

  function automatic logic parity_bad(input logic [31:0] d, input logic [3:0] p,
                                      input logic [3:0] s);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) if (s[i] && ((^d[8*i +: 8]) != p[i])) bad = 1'b1;
    return bad;
  endfunction

  // instance j: latency (j%2)+1, External parity for j>=2
  for (genvar g = 0; g < 4; g++) begin : g_dut
    wishbone_bram_pipelined #(
      .AddressWidth(12),
      .DataWidth   (32),
      .ReadLatency ((g % 2) + 1),
      .ParityMode  ((g >= 2) ? "External" : "Internal"),
      .DeviceType  ("Xilinx")
    ) u_dut (
      .CLK            (clk),
      .RST_n          (rst_n),
      .CYC            (cyc),
      .STB            (stb),
      .WE             (we),
      .ADDR           (addr),
      .SEL            (sel),
      .DAT_ToTarget   (dat),
      .TGD_ToTarget   (tgd),
      .DAT_ToInitiator(dat_o[g]),
      .TGD_ToInitiator(tgd_o[g]),
      .ACK            (ack[g]),
      .ERR            (err[g]),
      .STALL          (stall[g]),
      .ErrClear       (err_clear),
      .ErrCount       (err_count[g])
    );

    // scoreboard
    string tg;
    exp_t  e;
    initial tg = $sformatf("u%0d", g);
    always @(negedge clk) begin
      if (!rst_n) exp_cnt[g] = '0;
      check_eq({tg, "_stall"}, 64'(stall[g]), 64'(0));
      check_eq({tg, "_errcount"}, 64'(err_count[g]), 64'(exp_cnt[g]));
      if (exp_q[g].size() > 0 && exp_q[g][0].due == edge_n) begin
        e = exp_q[g].pop_front();
        check_eq({tg, "_ack"}, 64'(ack[g]), 64'(!e.exp_err));
        check_eq({tg, "_err"}, 64'(err[g]), 64'(e.exp_err));
        if (e.is_rd) begin
          check_eq({tg, "_rdata"}, 64'(dat_o[g]), 64'(e.data));
          check_eq({tg, "_rtgd"}, 64'(tgd_o[g]), 64'(e.par));
        end
        if (e.exp_err && exp_cnt[g] != 16'hFFFF) exp_cnt[g] = exp_cnt[g] + 16'd1;
      end else begin
        check_eq({tg, "_noresp"}, 64'({ack[g], err[g]}), 64'(0));
      end
      if (err_clear) exp_cnt[g] = '0;
    end
  end

  // driver tasks
  task automatic drive_req(input logic w, input logic [11:0] a, input logic [3:0] s,
                           input logic [31:0] d, input logic [3:0] t);
    exp_t e;
    cyc = 1'b1; stb = 1'b1; we = w; addr = a; sel = s; dat = d; tgd = t;
    for (int j = 0; j < 4; j++) begin
      e.due     = edge_n + (j % 2) + 1;
      e.is_rd   = !w;
      e.data    = m_data[a];
      e.par     = (j >= 2) ? m_pext[a] : m_pint[a];
      e.exp_err = !w && parity_bad(e.data, e.par, s);
      exp_q[j].push_back(e);
    end
    if (w) begin
      for (int i = 0; i < 4; i++) begin
        if (s[i]) begin
          m_data[a][8*i +: 8] = d[8*i +: 8];
          m_pint[a][i]        = ^d[8*i +: 8];
          m_pext[a][i]        = t[i];
        end
      end
    end
    @(posedge clk); #1;
    stb = 1'b0;
  endtask

  task automatic idle(input int n);
    stb = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // With CYC low, anything due in this cycle or later never terminates.
  task automatic drop_cyc();
    cyc = 1'b0; stb = 1'b0;
    for (int j = 0; j < 4; j++) begin
      while (exp_q[j].size() > 0 && exp_q[j][exp_q[j].size()-1].due >= edge_n)
        exp_q[j].delete(exp_q[j].size() - 1);
    end
    @(posedge clk); #1;
  endtask

  logic [31:0] rd_val;

  initial begin
    cyc = 0; stb = 0; we = 0; addr = 0; sel = 0; dat = 0; tgd = 0; err_clear = 0;
    for (int j = 0; j < 4; j++) exp_cnt[j] = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int j = 0; j < 4; j++) begin
      check_eq($sformatf("reset_ack%0d", j), 64'(ack[j]), 64'(0));
      check_eq($sformatf("reset_err%0d", j), 64'(err[j]), 64'(0));
      check_eq($sformatf("reset_dat%0d", j), 64'(dat_o[j]), 64'(0));
      check_eq($sformatf("reset_tgd%0d", j), 64'(tgd_o[j]), 64'(0));
      check_eq($sformatf("reset_cnt%0d", j), 64'(err_count[j]), 64'(0));
    end
    rst_n = 1'b1;
    idle(1);

    // full-word write then read back
    drive_req(1'b1, 12'h010, 4'hF, 32'hDEADBEEF, good_par(32'hDEADBEEF));
    drive_req(1'b0, 12'h010, 4'hF, 32'h0, 4'h0);
    idle(3);

    // byte-lane write merges into existing word
    drive_req(1'b1, 12'h005, 4'hF, 32'h11223344, good_par(32'h11223344));
    drive_req(1'b1, 12'h005, 4'b0101, 32'hAABBCCDD, good_par(32'hAABBCCDD));
    drive_req(1'b0, 12'h005, 4'hF, 32'h0, 4'h0);
    idle(3);

    // back-to-back reads of addr 0..3
    for (int i = 0; i < 4; i++) begin
      rd_val = $urandom;
      drive_req(1'b1, 12'(i), 4'hF, rd_val, good_par(rd_val));
    end
    for (int i = 0; i < 4; i++) drive_req(1'b0, 12'(i), 4'hF, 32'h0, 4'h0);
    idle(3);

    // external parity with a wrong bit on byte 0
    drive_req(1'b1, 12'h007, 4'hF, 32'h000000FF, 4'b0001);
    drive_req(1'b0, 12'h007, 4'b0001, 32'h0, 4'h0);
    drive_req(1'b0, 12'h007, 4'b1110, 32'h0, 4'h0);
    idle(3);
    check_eq("ext_errcount_l1", 64'(err_count[2]), 64'(1));
    check_eq("ext_errcount_l2", 64'(err_count[3]), 64'(1));

    // CYC drop aborts in-flight requests; next request after reassert responds
    drive_req(1'b0, 12'h000, 4'hF, 32'h0, 4'h0);
    drive_req(1'b0, 12'h001, 4'hF, 32'h0, 4'h0);
    drop_cyc();
    drive_req(1'b0, 12'h002, 4'hF, 32'h0, 4'h0);
    idle(3);

    // random traffic over a small address window
    for (int i = 16; i < 24; i++) begin
      rd_val = $urandom;
      drive_req(1'b1, 12'(i), 4'hF, rd_val, 4'($urandom_range(0, 15)));
    end
    for (int i = 0; i < 60; i++) begin
      drive_req(1'($urandom_range(0, 1)), 12'($urandom_range(16, 23)),
                4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(3);

    // asynchronous reset while a latency-2 read is terminating
    drive_req(1'b0, 12'h000, 4'hF, 32'h0, 4'h0);
    idle(1);
    rst_n = 1'b0; cyc = 1'b0;
    for (int j = 0; j < 4; j++) exp_q[j].delete();
    #1;
    check_eq("midreset_ack_l2", 64'(ack[1]), 64'(0));
    check_eq("midreset_ack_l2ext", 64'({ack[3], err[3]}), 64'(0));
    for (int j = 0; j < 4; j++)
      check_eq($sformatf("midreset_cnt%0d", j), 64'(err_count[j]), 64'(0));
    idle(2);
    rst_n = 1'b1;
    idle(4);

    // saturate the error counter, then clear it, then clear while ERR is high
    for (int i = 0; i < 65540; i++) drive_req(1'b0, 12'h007, 4'b0001, 32'h0, 4'h0);
    idle(3);
    check_eq("sat_hold_l1", 64'(err_count[2]), 64'(16'hFFFF));
    check_eq("sat_hold_l2", 64'(err_count[3]), 64'(16'hFFFF));
    err_clear = 1'b1;
    idle(1);
    err_clear = 1'b0;
    idle(1);
    check_eq("clear_l1", 64'(err_count[2]), 64'(0));
    check_eq("clear_l2", 64'(err_count[3]), 64'(0));
    drive_req(1'b0, 12'h007, 4'b0001, 32'h0, 4'h0);
    idle(1);
    err_clear = 1'b1;
    idle(1);
    err_clear = 1'b0;
    idle(2);
    check_eq("clear_prio_l2", 64'(err_count[3]), 64'(0));

    for (int j = 0; j < 4; j++)
      check_eq($sformatf("drained%0d", j), 64'(exp_q[j].size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
